// File: rtl/lc3_wait_mem_if.sv
// Bus between the LC-3 MAR/MDR side (master) and the wait-state memory model (slave).
interface lc3_wait_mem_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] mem_out;
    logic              ack;
    logic              busy;
    logic              init_done;
    logic              addr_err;
    logic [31:0]       rd_count;
    logic [31:0]       wr_count;

    modport master (
        output req, we, mar, mdr,
        input  mem_out, ack, busy, init_done, addr_err, rd_count, wr_count
    );

    modport slave (
        input  req, we, mar, mdr,
        output mem_out, ack, busy, init_done, addr_err, rd_count, wr_count
    );
endinterface

// File: rtl/lc3_wait_mem.sv
// Word-addressed LC-3 bench RAM with req/ack handshake, programmable wait states,
// post-reset clear sweep and range check. Access counters built only with LC3_MEM_STATS_EN.
module lc3_wait_mem #(
    parameter int              DATA_W      = 16,
    parameter int              ADDR_W      = 16,
    parameter int              DEPTH       = 1024,
    parameter int              WAIT_STATES = 0,
    parameter logic [DATA_W-1:0] INIT_VALUE = {DATA_W{1'b0}}
) (
    input logic          clk,
    input logic          reset,
    lc3_wait_mem_if.slave bus
);
    localparam int         IDX_W = $clog2(DEPTH);
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_IDLE   = 2'd1,
        S_WAIT   = 2'd2,
        S_ACCESS = 2'd3
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [IDX_W-1:0]  init_ptr_r;
    logic [3:0]        wcnt_r;
    logic              we_r;
    logic [ADDR_W-1:0] mar_r;
    logic [DATA_W-1:0] mdr_r;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] mem_out_r;
    logic              ack_r, busy_r, init_done_r, addr_err_r;

    logic              in_range_s, sweep_last_s, accept_s;
    logic              mem_wr_s, ack_nxt_s, err_nxt_s;
    logic [IDX_W-1:0]  mem_wr_idx_s;
    logic [DATA_W-1:0] mem_wr_data_s, out_nxt_s;

    // Upper address bits above the implemented depth must be zero.
    assign in_range_s   = ((mar_r >> IDX_W) == {ADDR_W{1'b0}});
    assign sweep_last_s = (state_r == S_INIT) && (init_ptr_r == IDX_W'(DEPTH - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= S_INIT;
        else       state_r <= state_nxt_s;
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_INIT:   if (sweep_last_s) state_nxt_s = S_IDLE; else state_nxt_s = S_INIT;
            S_IDLE: begin
                if (bus.req) state_nxt_s = (WS == 4'd0) ? S_ACCESS : S_WAIT;
                else         state_nxt_s = S_IDLE;
            end
            S_WAIT:   if (wcnt_r == 4'd1) state_nxt_s = S_ACCESS; else state_nxt_s = S_WAIT;
            S_ACCESS: state_nxt_s = S_IDLE;
            default:  state_nxt_s = S_INIT;
        endcase
    end

    // Output / memory-port decode; results are registered below.
    always_comb begin
        mem_wr_s      = 1'b0;
        mem_wr_idx_s  = init_ptr_r;
        mem_wr_data_s = INIT_VALUE;
        out_nxt_s     = mem_out_r;
        ack_nxt_s     = 1'b0;
        err_nxt_s     = 1'b0;
        accept_s      = 1'b0;
        case (state_r)
            S_INIT: mem_wr_s = 1'b1;
            S_IDLE: accept_s = bus.req;
            S_WAIT: ack_nxt_s = 1'b0;
            S_ACCESS: begin
                ack_nxt_s     = 1'b1;
                err_nxt_s     = ~in_range_s;
                mem_wr_idx_s  = mar_r[IDX_W-1:0];
                mem_wr_data_s = mdr_r;
                if (!in_range_s) begin
                    out_nxt_s = {DATA_W{1'b0}};
                    mem_wr_s  = 1'b0;
                end else if (we_r) begin
                    out_nxt_s = mdr_r;
                    mem_wr_s  = 1'b1;
                end else begin
                    out_nxt_s = mem_r[mar_r[IDX_W-1:0]];
                    mem_wr_s  = 1'b0;
                end
            end
            default: mem_wr_s = 1'b0;
        endcase
    end

    // Storage array; a reset edge suppresses any pending write.
    always_ff @(posedge clk) begin
        if (!reset && mem_wr_s) mem_r[mem_wr_idx_s] <= mem_wr_data_s;
    end

    // Request latch, wait counter, sweep pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            init_ptr_r  <= {IDX_W{1'b0}};
            wcnt_r      <= 4'd0;
            we_r        <= 1'b0;
            mar_r       <= {ADDR_W{1'b0}};
            mdr_r       <= {DATA_W{1'b0}};
            mem_out_r   <= {DATA_W{1'b0}};
            ack_r       <= 1'b0;
            addr_err_r  <= 1'b0;
            init_done_r <= 1'b0;
            busy_r      <= 1'b1;
        end else begin
            if (state_r == S_INIT) init_ptr_r <= init_ptr_r + IDX_W'(1'b1);
            if (sweep_last_s)      init_done_r <= 1'b1;
            if (accept_s) begin
                we_r   <= bus.we;
                mar_r  <= bus.mar;
                mdr_r  <= bus.mdr;
                wcnt_r <= WS;
            end else if (state_r == S_WAIT) begin
                wcnt_r <= wcnt_r - 4'd1;
            end
            mem_out_r  <= out_nxt_s;
            ack_r      <= ack_nxt_s;
            addr_err_r <= err_nxt_s;
            busy_r     <= (state_nxt_s != S_IDLE);
        end
    end

    assign bus.mem_out   = mem_out_r;
    assign bus.ack       = ack_r;
    assign bus.addr_err  = addr_err_r;
    assign bus.init_done = init_done_r;
    assign bus.busy      = busy_r;

`ifdef LC3_MEM_STATS_EN
    logic [31:0] rd_cnt_r, wr_cnt_r;

    // Saturating counts of completed in-range accesses.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_r <= 32'd0;
            wr_cnt_r <= 32'd0;
        end else if (state_r == S_ACCESS && in_range_s) begin
            if (!we_r && rd_cnt_r != 32'hFFFF_FFFF) rd_cnt_r <= rd_cnt_r + 32'd1;
            if (we_r && wr_cnt_r != 32'hFFFF_FFFF)  wr_cnt_r <= wr_cnt_r + 32'd1;
        end
    end

    assign bus.rd_count = rd_cnt_r;
    assign bus.wr_count = wr_cnt_r;
`else
    assign bus.rd_count = 32'd0;
    assign bus.wr_count = 32'd0;
`endif
endmodule

// File: doc/lc3_wait_mem.md
Name: lc3_wait_mem

Overview:
- Parametrised successor to the fixed single-cycle LC-3 bench memory model.
- Word-addressed synchronous RAM with configurable data width, address width, depth and programmable wait states.
- Uses a req/ack handshake, a post-reset clear sweep and out-of-range address detection.
- Sits between the LC-3 MAR/MDR bus and the bench; lets the CPU be exercised against slow memory.

Parameters:
DATA_W, 16, data word width in bits
ADDR_W, 16, address (MAR) width in bits
DEPTH, 1024, words implemented; power of 2, 2 <= DEPTH <= 2**ADDR_W
WAIT_STATES, 0, extra cycles per access, legal range 0..15
INIT_VALUE, 0, DATA_W-bit value written to every word by the clear sweep

Ports:
clk  input  1  single clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
req  input  1  access request, sampled only in IDLE
we  input  1  1 = write, 0 = read; sampled with req
mar  input  ADDR_W  word address; sampled with req
mdr  input  DATA_W  write data; sampled with req
mem_out  output  DATA_W  read data; valid while ack=1, held until next ack
ack  output  1  one-cycle completion pulse
busy  output  1  high in any state other than IDLE
init_done  output  1  high once the clear sweep has finished
addr_err  output  1  qualifies ack: access was out of range
rd_count  output  32  completed reads (optional feature)
wr_count  output  32  completed writes (optional feature)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- On reset (at the clock edge):
  - state=INIT, init_ptr=0.
  - mem_out=0, ack=0, addr_err=0, init_done=0, busy=1.
  - rd_count=0, wr_count=0.
- States: INIT, IDLE, WAIT, ACCESS.
- INIT:
  - Each cycle write INIT_VALUE to mem[init_ptr], then init_ptr++.
  - At the edge that writes mem[DEPTH-1]: go to IDLE and set init_done=1.
  - Sweep takes exactly DEPTH cycles; req is ignored throughout.
- IDLE:
  - At an edge with req=1: latch we, mar and mdr.
  - WAIT_STATES=0: go to ACCESS. Otherwise: load wcnt=WAIT_STATES and go to WAIT.
- WAIT: wcnt decrements each edge; at the edge where wcnt==1, go to ACCESS.
- ACCESS (one cycle):
  - On the exiting edge, ack=1 for the following cycle and state returns to IDLE.
  - Read: mem_out = mem[mar].
  - Write: mem[mar] = mdr, and mem_out = mdr (write-through).
- Latency: request sampled at edge E0 -> ack high in the cycle after edge E0+WAIT_STATES+1.
- Throughput: req held high yields one access per WAIT_STATES+2 cycles.
  - In the ack cycle the state is IDLE, so req=1 there is a new request.
- req, we, mar and mdr are don't-care outside IDLE. Latched values are used, so changing inputs mid-access has no effect.
- Range check: in range when mar[ADDR_W-1:log2(DEPTH)]==0; always in range when DEPTH==2**ADDR_W.
  - Out of range: access still completes with normal latency and addr_err=1 with ack.
  - A write is suppressed and mem_out=0.
- addr_err is 0 whenever ack is 0.
- Reset mid-access (any state): access aborted, no memory write, no ack, clear sweep restarts.
- mem_out holds its value between acks.

Optional Feature:
- Macro: LC3_MEM_STATS_EN.
- Defined:
  - rd_count / wr_count increment on each acked read / write with addr_err=0.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: counter logic is not built and rd_count / wr_count are tied to 0; ports remain present.

Test Plan:
- DEPTH=16, reset for 1 cycle -> busy=1 and init_done=0 for 16 cycles; init_done=1 on cycle 16; a read of any address returns INIT_VALUE (0).
- WAIT_STATES=0, write mar=16'h0005 mdr=16'h1234, then read 16'h0005 -> write ack 1 cycle after req, mem_out=16'h1234 on both acks, addr_err=0.
- WAIT_STATES=3, req held high for read of 16'h0002 -> ack pulses every 5 cycles, first ack in cycle 4 after accept edge, busy=1 between.
- DEPTH=1024, write mar=16'h0400 mdr=16'hBEEF -> ack with addr_err=1, mem_out=0; read mar=16'h0000 afterwards returns INIT_VALUE (no aliasing write).
- WAIT_STATES=4, write mar=16'h0003 mdr=16'hAAAA, assert reset in the 2nd WAIT cycle -> no ack, sweep restarts; after init_done, read 16'h0003 returns INIT_VALUE.
- LC3_MEM_STATS_EN defined, 3 in-range reads + 2 in-range writes + 1 out-of-range write -> rd_count=3, wr_count=2; macro undefined -> both read 0.
